// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential multiplier.
// State encoding and iteration bounds live here.
package mult_pkg;

  localparam int WIDTH     = 32;
  localparam int ITER_LAST = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_32_if.sv
// Start/busy/done handshake bundle for seq_mult_32.
// The controller drives operands; the multiplier returns status and result.
interface seq_mult_32_if;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/full_adder_32.sv
// 32-bit ripple-carry adder, purely combinational.
// The multiplier uses it as its only adder.
module full_adder_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic carry;

  // Ripple the carry from bit 0 upward
  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < 32; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mult_32.sv
// Unsigned 32x32 -> 64 shift-and-add multiplier, one bit per clock.
// acc_lo starts as the multiplier and shifts out as product bits shift in.
module seq_mult_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mult_32_if.slave bus
);

  import mult_pkg::*;

  if (WIDTH != mult_pkg::WIDTH) begin : g_bad_width
    $error("seq_mult_32: only WIDTH=32 is supported");
  end

  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("seq_mult_32: CNT_W too small to hold WIDTH");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_LAST);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_y;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;

  assign add_y = acc_lo_q[0] ? mcand_q : '0;

  full_adder_32 u_add (
    .x    (acc_hi_q),
    .y    (add_y),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  // The adder carry becomes the new top bit after the shift
  assign shifted = {cout, sum, acc_lo_q[WIDTH-1:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          acc_lo_d = bus.b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = shifted;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// Self-checking bench for seq_mult_32.
// A cycle-count model predicts busy/done/product from a*b.
module tb_seq_mult_32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seq_mult_32_if bus ();

  seq_mult_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: cycles elapsed since an accepted start (0 = idle)
  int          m_cyc  = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  = 0;
      m_pend = '0;
      m_prod = '0;
    end else if (m_cyc == 0) begin
      if (bus.start) begin
        m_pend = {32'b0, bus.a} * {32'b0, bus.b};
        m_cyc  = 1;
      end
    end else begin
      m_cyc = m_cyc + 1;
      if (m_cyc == 33) m_prod = m_pend;
      if (m_cyc == 34) m_cyc = 0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", 64'(bus.busy), 64'(m_cyc >= 1 && m_cyc <= 33));
        check("done", 64'(bus.done), 64'(m_cyc == 33));
        check("product", bus.product, m_prod);
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input bit noise,
                        input string nm);
    int k;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (bus.done) break;
      if (k == 1) begin
        bus.start = 1'b0;
        check({nm, "_busy1"}, 64'(bus.busy), 64'd1);
      end
      if (noise) begin
        if (k < 30) begin
          bus.start = 1'($urandom % 2);
          bus.a     = $urandom;
          bus.b     = $urandom;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    check({nm, "_lat"}, 64'(k), 64'd33);
    check({nm, "_prod"}, bus.product, exp);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm, input logic [63:0] exp);
    int k;
    k = 0;
    while (k < 80) begin
      @(negedge clk);
      k++;
      if (bus.done) break;
    end
    check({nm, "_seen"}, 64'(bus.done), 64'd1);
    check({nm, "_prod"}, bus.product, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", bus.product, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op(32'd3, 32'd5, 64'd15, 1'b0, "basic");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, "max");
    run_op(32'd0, 32'h12345678, 64'd0, 1'b0, "zero");
    run_op(32'h12345678, 32'd1, 64'h0000000012345678, 1'b0, "ident");

    // start held high through RUN/DONE with new operands
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 32'd100;
    bus.b = 32'd100;
    wait_done("hold1", 64'd63);
    wait_done("hold2", 64'd10000);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    // async reset in the middle of an operation
    bus.a     = 32'hFFFF;
    bus.b     = 32'hFFFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_product", bus.product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd3, 64'd6, 1'b0, "after_rst");

    // product holds while idle
    run_op(32'd6, 32'd7, 64'd42, 1'b0, "hold_src");
    for (int i = 0; i < 20; i++) begin
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
      check("idle_product", bus.product, 64'd42);
      check("idle_done", 64'(bus.done), 64'd0);
    end

    // randomized operands, some with start noise while busy
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 3) ra = 32'hFFFFFFFF;
      if (i % 9 == 4) rb = 32'd0;
      run_op(ra, rb, {32'b0, ra} * {32'b0, rb}, 1'(i % 2), "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult_32.md
Name: seq_mult_32

Overview:
- Unsigned 32x32 -> 64-bit shift-and-add multiplier; one multiplier bit per clock.
- Sits directly downstream of the 32-bit ripple adder stage. It instantiates full_adder_32 as its only adder and consumes its s/cout every cycle.
- Intended as the next datapath block after the adder/subtractor exercise. It provides a start/busy/done handshake to a controlling FSM or testbench.

Parameters:
- WIDTH, 32, operand width; fixed by full_adder_32; only 32 supported, elaborate-time error otherwise.
- CNT_W, 6, width of iteration counter; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  32  multiplicand; captured on accepted start.
- b  input  32  multiplier; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  single-cycle pulse; product is valid.
- product  output  64  result; holds until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, internal regs=0, count=0. Release is synchronous to clk; the first start is honoured on the first edge after release.
- Registers:
  - mcand[31:0]
  - acc_hi[31:0]
  - acc_lo[31:0] (holds the multiplier and shifts out)
  - count[CNT_W-1:0]
- Adder hookup: x=acc_hi, y=(acc_lo[0] ? mcand : 0), cin=0 -> {cout,s}.
- State IDLE:
  - start=1 at edge -> mcand<=a, acc_lo<=b, acc_hi<=0, count<=0, state<=RUN.
  - start=0 -> stay.
- State RUN, each edge:
  - {acc_hi,acc_lo} <= {cout, s, acc_lo[31:1]}. This shifts the 65-bit {cout,s,acc_lo} right by 1.
  - count<=count+1.
  - When count==31 at the edge -> state<=DONE.
- State DONE (one cycle):
  - product={acc_hi,acc_lo}, registered at RUN->DONE edge; done=1, busy=1.
  - Next edge -> IDLE.
- Latency: start sampled at edge E0; done high during cycle after edge E0+32 (edges E1..E32 are RUN iterations). Total 33 cycles start-to-done. Throughput: one result per 34 cycles minimum; start is accepted again in IDLE only.
- start during RUN or DONE: ignored, no queuing, operands not re-captured.
- a/b may change after the accept edge without effect.
- product changes only at the RUN->DONE edge; stable across IDLE and during the next RUN until its DONE.
- No early termination on zero operands; always 32 iterations.
- Reset mid-RUN: immediate abort to IDLE, product cleared to 0, no done pulse.
- cout from the adder is never dropped; it becomes acc_hi[31] after the shift.

Decomposition:
- Shared package mult_pkg:
  - state enum IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparams WIDTH=32, ITER_LAST=31.
- One sub-module: the existing full_adder_32 (x, y, cin, s, cout), instantiated once, combinational.
- Everything else stays in seq_mult_32.

Test Plan:
- Basic: a=3, b=5, pulse start -> busy next cycle; done exactly 33 cycles after the start edge; product=64'd15.
- Max carry: a=b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; checks cout propagation into acc_hi.
- Zero and identity: a=0, b=32'h12345678 -> product=0; then a=32'h12345678, b=1 -> product=64'h0000000012345678; both 33-cycle latency.
- Start while busy: accept a=7, b=9; hold start=1 with a=100, b=100 through RUN/DONE -> first done gives 63. Start stays high, so the next IDLE accepts 100*100 -> product=10000 on the second done.
- Reset mid-operation: a=32'hFFFF, b=32'hFFFF; drop rst_n at iteration 10 for 2 cycles -> busy=0, done=0, product=0 immediately (async). A new start a=2, b=3 -> product=6 after 33 cycles.
- Product hold: after a=6, b=7 -> 42, idle 20 cycles with random a/b, start=0 -> product stays 42, done stays 0.
